// File: rtl/chord_sequencer.sv
// Chord sequencer: plays up to eight 8-voice chord entries from a small pattern memory.
// Each step sounds for STEP_CYCLES-GAP_CYCLES cycles, then stays silent for GAP_CYCLES cycles.
module chord_sequencer #(
  parameter int STEP_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 1250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [2:0] len,
  input  logic       loop,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] chord,
  output logic [2:0] step,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(STEP_CYCLES + 1);
  localparam logic [CW-1:0] PLAY_LOAD = CW'(STEP_CYCLES - GAP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      step_q, step_d;
  logic [2:0]      len_q, len_d;
  logic [7:0]      chord_q, chord_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2:0]      next_step;
  logic [7:0]      mem_q [8];
  logic [7:0]      mem_d [8];

  // Register array (not block RAM) because reset must clear every entry.
  for (genvar gi = 0; gi < 8; gi++) begin : g_mem
    assign mem_d[gi] = (wr_en && (wr_addr == 3'(gi))) ? wr_data : mem_q[gi];

    always_ff @(posedge clk) begin
      if (rst) mem_q[gi] <= 8'h00;
      else     mem_q[gi] <= mem_d[gi];
    end
  end

  assign next_step = step_q + 3'd1;

  // Chord loads read mem_q, so a same-edge write is seen only on the next load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    len_d   = len_q;
    chord_d = chord_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_PLAY;
          cnt_d   = PLAY_LOAD;
          step_d  = 3'd0;
          len_d   = len;
          chord_d = mem_q[0];
          busy_d  = 1'b1;
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          step_d  = 3'd0;
          chord_d = 8'h00;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
          chord_d = 8'h00;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          step_d  = 3'd0;
          chord_d = 8'h00;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (step_q < len_q) begin
          state_d = S_PLAY;
          cnt_d   = PLAY_LOAD;
          step_d  = next_step;
          chord_d = mem_q[next_step];
        end else if (loop) begin
          state_d = S_PLAY;
          cnt_d   = PLAY_LOAD;
          step_d  = 3'd0;
          chord_d = mem_q[0];
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
          step_d  = 3'd0;
          chord_d = 8'h00;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        step_d  = 3'd0;
        chord_d = 8'h00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= 3'd0;
      len_q   <= 3'd0;
      chord_q <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      len_q   <= len_d;
      chord_q <= chord_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign chord = chord_q;
  assign step  = step_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_chord_sequencer.sv
// Scoreboard bench for chord_sequencer: a step/position timeline model predicts every
// cycle's outputs; a negedge monitor pops those predictions and compares.
module tb_chord_sequencer;

  localparam int STEP = 10;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst, wr_en, loop, start, stop;
  logic [2:0] wr_addr, len;
  logic [7:0] wr_data;
  logic [7:0] chord;
  logic [2:0] step;
  logic       busy, done;

  chord_sequencer #(.STEP_CYCLES(STEP), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .loop(loop), .start(start), .stop(stop),
    .chord(chord), .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] chord;
    logic [2:0] step;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model: a step is a window of STEP cycles; the chord sounds for the
  // first STEP-GAP positions of that window and is silent for the rest.
  logic [7:0] m_mem [8];
  bit         m_active = 0;
  int         m_cur = 0, m_pos = 0, m_len = 0;
  logic [7:0] m_snap = 8'h00;

  always @(posedge clk) begin
    exp_t e;
    bit   fin;
    fin = 0;
    if (rst) begin
      m_active = 0; m_cur = 0; m_pos = 0; m_len = 0; m_snap = 8'h00;
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    end else begin
      if (m_active && stop) begin
        m_active = 0;
      end else if (!m_active && start && !stop) begin
        m_active = 1; m_cur = 0; m_pos = 0; m_len = int'(len); m_snap = m_mem[0];
      end else if (m_active) begin
        m_pos++;
        if (m_pos == STEP) begin
          m_pos = 0;
          if (m_cur < m_len) begin
            m_cur++;
            m_snap = m_mem[m_cur];
          end else if (loop) begin
            m_cur = 0;
            m_snap = m_mem[0];
          end else begin
            m_active = 0;
            fin = 1;
          end
        end
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
    end
    e.busy  = m_active;
    e.chord = (m_active && m_pos < STEP - GAP) ? m_snap : 8'h00;
    e.step  = m_active ? 3'(m_cur) : 3'd0;
    e.done  = fin;
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("chord", chord, e.chord);
      chk("busy", 8'(busy), 8'(e.busy));
      chk("done", 8'(done), 8'(e.done));
      if (e.busy) chk("step", 8'(step), 8'(e.step));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
    len = 3'd0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    idle(3);
    rst = 1'b0;

    $display("txn 1: three-step pattern, no loop");
    wr(3'd0, 8'h01); wr(3'd1, 8'h12); wr(3'd2, 8'h80);
    len = 3'd2; loop = 1'b0;
    do_start();
    idle(34);

    $display("txn 2: loop, then drop loop mid-pass");
    loop = 1'b1;
    do_start();
    idle(40);
    loop = 1'b0;
    idle(40);

    $display("txn 3: stop at T+5, restart at T+10");
    do_start();
    idle(4);
    do_stop();
    idle(4);
    do_start();
    idle(35);

    $display("txn 4: write to sounding step and same-edge write/load of mem[0]");
    loop = 1'b1;
    do_start();
    idle(14);
    wr(3'd1, 8'hFF);
    idle(14);
    wr(3'd0, 8'h5A);
    idle(25);
    loop = 1'b0;
    idle(40);

    $display("txn 5: start while busy");
    do_start();
    idle(5);
    do_start();
    idle(35);

    $display("txn 6: start and stop together in idle");
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    idle(5);

    $display("txn 7: len=0 single step, len changed during playback");
    len = 3'd0;
    do_start();
    len = 3'd5;
    idle(15);

    $display("txn 8: rst at T+15 with start and write on the reset edge");
    len = 3'd2;
    do_start();
    idle(14);
    rst = 1'b1; start = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h77;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; wr_en = 1'b0;
    idle(3);
    len = 3'd7;
    do_start();
    idle(85);

    $display("txn 9: randomized stimulus");
    for (int i = 0; i < 800; i++) begin
      rst     = ($urandom % 150) == 0;
      start   = ($urandom % 15) == 0;
      stop    = ($urandom % 50) == 0;
      wr_en   = ($urandom % 6) == 0;
      wr_addr = 3'($urandom);
      wr_data = 8'($urandom);
      if (($urandom % 40) == 0) loop = ~loop;
      if (($urandom % 20) == 0) len = 3'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chord_sequencer.md
CHORD_SEQUENCER -- requirements
Module: chord_sequencer

Interface
REQ-001 Parameter STEP_CYCLES, default 12500000: total clk cycles per sequence step (sound plus gap).
REQ-002 Parameter GAP_CYCLES, default 1250000: silent clk cycles at the end of each step; legal only when 1 <= GAP_CYCLES < STEP_CYCLES.
REQ-003 Port clk, input, 1: single clock for all logic.
REQ-004 Port rst, input, 1: reset, synchronous to clk, active-high.
REQ-005 Port wr_en, input, 1: pattern-memory write strobe.
REQ-006 Port wr_addr, input, 3: pattern-memory write address.
REQ-007 Port wr_data, input, 8: chord entry to write; bit i enables divider voice i.
REQ-008 Port len, input, 3: index of the last step; sequence length is len+1.
REQ-009 Port loop, input, 1: level; repeat the sequence after its last step.
REQ-010 Port start, input, 1: single-cycle pulse that begins playback.
REQ-011 Port stop, input, 1: single-cycle pulse that aborts playback.
REQ-012 Port chord, output, 8: registered chord vector that drives the 8-voice divider bank.
REQ-013 Port step, output, 3: index of the current step.
REQ-014 Port busy, output, 1: high in the PLAY and GAP states.
REQ-015 Port done, output, 1: one-cycle pulse when a non-looping sequence completes.

Function
REQ-016 Internal storage: 8 x 8-bit pattern memory; writes occur on any clk edge where wr_en=1, in every state.
REQ-017 FSM states: IDLE, PLAY, GAP; a single down-counter tracks the cycles spent in the current state.
REQ-018 IDLE with start=1 and stop=0: next cycle state=PLAY, step=0, chord=mem[0], busy=1, len latched into len_q.
REQ-019 PLAY lasts exactly STEP_CYCLES-GAP_CYCLES cycles, then the FSM enters GAP.
REQ-020 GAP lasts exactly GAP_CYCLES cycles, with chord=0 throughout.
REQ-021 End of GAP, step<len_q: state=PLAY, step=step+1, chord=mem[step+1].
REQ-022 End of GAP, step==len_q, loop=1: state=PLAY, step=0, chord=mem[0]; loop is sampled at this edge only.
REQ-023 End of GAP, step==len_q, loop=0: state=IDLE, chord=0, busy=0, and done=1 for exactly one cycle.
REQ-024 Every step therefore occupies exactly STEP_CYCLES cycles, measured from chord load to the next chord load.
REQ-025 chord is loaded from memory only on entry to PLAY; a write to the sounding step does not change chord until that step is next entered.
REQ-026 Write and load of the same address on the same edge: the load takes the old data (read-before-write).
REQ-027 stop=1 in PLAY or GAP: next cycle state=IDLE, chord=0, busy=0, step=0, done=0.
REQ-028 stop=1 in IDLE has no effect.
REQ-029 start=1 while busy=1 is ignored.
REQ-030 start and stop asserted on the same cycle: stop wins, and the block stays in or goes to IDLE.
REQ-031 Changes to len during playback are ignored until the next start; len=0 plays a single step.
REQ-032 step wraps only via REQ-022; step never exceeds len_q.

Reset
REQ-033 rst=1 at a clk edge forces state=IDLE, chord=0, step=0, busy=0, done=0, counter=0, len_q=0, and all pattern-memory entries=0.
REQ-034 rst has priority over start, stop, and wr_en asserted on the same edge.
REQ-035 rst asserted mid-playback aborts playback the next cycle with no done pulse.

Verification (STEP_CYCLES=10, GAP_CYCLES=2)
REQ-036 Setup: write mem[0..2]=8'h01, 8'h12, 8'h80; len=2, loop=0; pulse start at cycle T.
- Response: chord=01 for cycles T+1..T+8, 00 for T+9..T+10, 12 for T+11..T+18, 00 for T+19..T+20, 80 for T+21..T+28, 00 for T+29..T+30.
- Then IDLE; done=1 at T+31 only; busy falls at T+31.
REQ-037 Loop: same pattern with loop=1; after step 2's gap, step=0 and chord=01 at T+31. Drop loop mid-pass: the sequence ends after the next step-2 gap with a single done pulse.
REQ-038 Stop: pulse stop at T+5 -> at T+6 chord=00, busy=0, step=0, and no done pulse; a new start at T+10 restarts from step 0.
REQ-039 Write conflict: while step 1 sounds, write mem[1]=8'hFF -> chord stays 12 until step end; with loop=1, the next pass plays FF at step 1. Simultaneous write and load of mem[0] with new data -> the load shows the old value.
REQ-040 Edge cases:
- start during busy -> timing unchanged.
- start+stop on the same IDLE cycle -> stays IDLE.
- len=0 -> one step of 10 cycles, then done.
- rst at T+15 -> all outputs zero at T+16 and memory reads back 00.
